// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle for the register file.
interface reg_file_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  modport master(output we, waddr, wdata, raddr1, raddr2, input rdata1, rdata2);
  modport slave(input we, waddr, wdata, raddr1, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Defining REG_FILE_BYPASS_EN forwards a same-cycle write to matching read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [1:N-1];
  // Per-entry compare so an unknown enable can only touch the addressed entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 1; i < N; i++) regs[i] <= '0;
    else
      for (int i = 1; i < N; i++)
        if (bus.we && bus.waddr == ADDR_W'(i)) regs[i] <= bus.wdata;
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && bus.we && bus.waddr != '0 && bus.waddr == a) return bus.wdata;
`endif
    return a == '0 ? '0 : regs[a];
  endfunction
  always_comb begin
    bus.rdata1 = rd(bus.raddr1);
    bus.rdata2 = rd(bus.raddr2);
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized scoreboard bench for reg_file against an array model.
module tb_reg_file;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus();
  reg_file #(.DATA_W(32), .ADDR_W(5)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string       name;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;
  exp_t        q[$];
  logic [31:0] model [32];
  int          vectors = 0;
  int          miscompares = 0;
  event        chk;
  function automatic logic [31:0] expv(input logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we && bus.waddr != 0 && bus.waddr == a) return bus.wdata;
`endif
    return model[a];
  endfunction
  task automatic push(input string name);
    exp_t e;
    e.name = name;
    e.a1 = bus.raddr1;
    e.a2 = bus.raddr2;
    e.e1 = expv(bus.raddr1);
    e.e2 = expv(bus.raddr2);
    q.push_back(e);
    ->chk;
  endtask
  task automatic step(input string name, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2);
    bus.we = w;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.raddr1 = a1;
    bus.raddr2 = a2;
    #1 push(name);
    @(posedge clk);
    if (rst_n && w && wa != 0) model[wa] = wd;
    @(negedge clk);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 0;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(chk);
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        e = q.pop_front();
        vectors++;
        if (bus.rdata1 !== e.e1 || bus.rdata2 !== e.e2) begin
          miscompares++;
          $display("FAIL %s: raddr1=%0d rdata1=%h want %h, raddr2=%0d rdata2=%h want %h",
                   e.name, e.a1, bus.rdata1, e.e1, e.a2, bus.rdata2, e.e2);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    clear_model();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr1 = 0; bus.raddr2 = 0;
    @(negedge clk);
    step("reset_state", 1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd0);
    rst_n = 1;
    step("load_r5", 1, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
    step("r5_loaded", 0, 5'd0, 32'h0, 5'd5, 5'd5);
    bus.raddr1 = 5; bus.raddr2 = 1; bus.we = 0;
    #2 rst_n = 0;
    clear_model();
    #1 push("async_reset");
    @(negedge clk);
    for (int i = 0; i < 32; i++) step("in_reset_sweep", 1, 5'(i), 32'hCAFE_0000 + i, 5'(i), 5'(31 - i));
    rst_n = 1;
    for (int i = 1; i < 32; i++) step("write_all", 1, 5'(i), 32'hA5A5_0000 + i, 5'(i - 1), 5'(i));
    for (int i = 0; i < 32; i++) step("sweep", 0, 5'(i), 32'h0, 5'(i), 5'(31 - i));
    step("r0_write", 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) step("r0_sweep", 0, 5'd0, 32'h0, 5'(i), 5'(i));
    step("r7_set", 1, 5'd7, 32'h11, 5'd0, 5'd0);
    step("we_gate", 0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
    step("we_gate_after", 0, 5'd0, 32'h0, 5'd7, 5'd7);
    step("r9_set", 1, 5'd9, 32'h100, 5'd0, 5'd0);
    step("collision", 1, 5'd9, 32'h200, 5'd9, 5'd9);
    step("collision_after", 0, 5'd0, 32'h0, 5'd9, 5'd9);
    step("r3_set", 1, 5'd3, 32'h77, 5'd3, 5'd3);
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h55;
    @(posedge clk);
    rst_n = 0;
    clear_model();
    @(negedge clk);
    bus.we = 0;
    rst_n = 1;
    step("reset_vs_write", 0, 5'd0, 32'h0, 5'd3, 5'd3);
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      step("random", 1'($urandom), wa, $urandom,
           ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
